// File: rtl/fifo_drain_ser.sv
// ---------------------------------------------------------------------------
// fifo_drain_ser
//   Read-side companion for the byte FIFO. Pops one byte per frame through a
//   one-cycle read strobe and shifts it out MSB first. Every frame carries a
//   valid strobe and a start-of-frame marker on the first bit. Optional
//   trailing even-parity bit, then a programmable idle gap.
//
// Configuration macro:
//   PARITY_EN  when defined, a one-cycle parity bit follows the data bits.
//
// Parameters:
//   DATA_W      byte width (>= 2)
//   GAP_CYCLES  idle cycles after each frame (0 = no gap)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          drain enable, sampled only in IDLE
//   i_fifo_empty  upstream FIFO empty flag, sampled only in IDLE
//   i_fifo_data   upstream FIFO read data, valid the cycle after o_fifo_rd
//   o_fifo_rd     one-cycle read strobe per byte
//   o_sdo         serial data
//   o_sdo_valid   high while o_sdo carries a data or parity bit
//   o_sof         high with the MSB of each frame
//   o_busy        high in every state except IDLE
//   o_byte_cnt    frames transmitted, wraps silently at 16 bits
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module fifo_drain_ser #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_sdo,
  output logic              o_sdo_valid,
  output logic              o_sof,
  output logic              o_busy,
  output logic [15:0]       o_byte_cnt
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(DATA_W - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapture,
    StShift,
`ifdef PARITY_EN
    StPar,
`endif
    StGap
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_d;
  logic [CntW-1:0]   r_bit_cnt;
  logic [GapW-1:0]   r_gap_cnt;
  logic              w_frame_done;
  logic              w_fifo_rd_d;
  logic              w_sdo_d;
  logic              w_sdo_valid_d;
  logic              w_sof_d;
  logic              w_busy_d;
`ifdef PARITY_EN
  logic              r_par;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (i_en && !i_fifo_empty) begin
          w_state_d = StReq;
        end
      end
      StReq:     w_state_d = StCapture;
      StCapture: w_state_d = StShift;
      StShift: begin
        if (r_bit_cnt == BitLast) begin
`ifdef PARITY_EN
          w_state_d = StPar;
`else
          w_state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
`endif
        end
      end
`ifdef PARITY_EN
      StPar:     w_state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
`endif
      StGap: begin
        if (r_gap_cnt == GapLast) begin
          w_state_d = StIdle;
        end
      end
      default:   w_state_d = StIdle;
    endcase
  end

  // Shift register next value: its MSB is always the bit on o_sdo during SHIFT
  always_comb begin
    w_shift_d = r_shift;
    if (r_state == StCapture) begin
      w_shift_d = i_fifo_data;
    end else if (r_state == StShift) begin
      w_shift_d = {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  // Last bit of the frame is being driven this cycle
`ifdef PARITY_EN
  assign w_frame_done = (r_state == StPar);
`else
  assign w_frame_done = (r_state == StShift) && (r_bit_cnt == BitLast);
`endif

  // Output logic: computed from the next state so every output is a flop
  always_comb begin
    w_fifo_rd_d   = (w_state_d == StReq);
    w_busy_d      = (w_state_d != StIdle);
    w_sof_d       = (r_state == StCapture);
    w_sdo_valid_d = (w_state_d == StShift);
    w_sdo_d       = 1'b0;
    if (w_state_d == StShift) begin
      w_sdo_d = w_shift_d[DATA_W-1];
    end
`ifdef PARITY_EN
    if (w_state_d == StPar) begin
      w_sdo_valid_d = 1'b1;
      w_sdo_d       = r_par;
    end
`endif
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fifo_rd   <= 1'b0;
      o_sdo       <= 1'b0;
      o_sdo_valid <= 1'b0;
      o_sof       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_fifo_rd   <= w_fifo_rd_d;
      o_sdo       <= w_sdo_d;
      o_sdo_valid <= w_sdo_valid_d;
      o_sof       <= w_sof_d;
      o_busy      <= w_busy_d;
    end
  end

  // Datapath: shift register, bit/gap counters, frame counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      o_byte_cnt <= '0;
    end else begin
      r_shift <= w_shift_d;
      if (r_state == StShift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_bit_cnt <= '0;
      end
      if (r_state == StGap) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
      if (w_frame_done) begin
        o_byte_cnt <= o_byte_cnt + 16'd1;
      end
    end
  end

`ifdef PARITY_EN
  // Even parity of the captured byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par <= 1'b0;
    end else if (r_state == StCapture) begin
      r_par <= ^i_fifo_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ser.sv
`timescale 1ns / 1ps

module tb_fifo_drain_ser;

`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int Period = 3 + 8 + P + 2;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_fifo_empty;
  logic [7:0]  i_fifo_data;
  logic        o_fifo_rd;
  logic        o_sdo;
  logic        o_sdo_valid;
  logic        o_sof;
  logic        o_busy;
  logic [15:0] o_byte_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [7:0]  q[$];

  fifo_drain_ser #(
    .DATA_W     (8),
    .GAP_CYCLES (2)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_sdo        (o_sdo),
    .o_sdo_valid  (o_sdo_valid),
    .o_sof        (o_sof),
    .o_busy       (o_busy),
    .o_byte_cnt   (o_byte_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: data presented after each read strobe
  always @(negedge clk) begin
    if (o_fifo_rd === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      if (q.size() > 0) i_fifo_data = q.pop_front();
    end
    i_fifo_empty = (q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_frame(input logic [7:0] b);
`ifdef PARITY_EN
    return {7'd0, b, ^b};
`else
    return {8'd0, b};
`endif
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Collects one frame: waits for the read strobe, then records the serial bits
  task automatic capture_frame(input int drop_en_bit, output logic [15:0] bits,
                               output int nbits, output int rd_cyc, output int lat,
                               output int rd_w, output logic sof_first,
                               output logic sof_extra, output bit tmo);
    int t;
    bits = '0; nbits = 0; rd_cyc = 0; lat = 0; rd_w = 0;
    sof_first = 1'b0; sof_extra = 1'b0; tmo = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_fifo_rd !== 1'b1 && t < 200);
    if (o_fifo_rd !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    rd_cyc = cyc;
    while (o_fifo_rd === 1'b1 && rd_w < 5) begin
      rd_w++;
      @(negedge clk);
    end
    lat = rd_w;
    while (o_sdo_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (o_sdo_valid !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    sof_first = o_sof;
    while (o_sdo_valid === 1'b1 && nbits < 16) begin
      bits = {bits[14:0], o_sdo};
      if (nbits > 0 && o_sof === 1'b1) sof_extra = 1'b1;
      if (nbits == drop_en_bit) i_en = 1'b0;
      nbits++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_fifo_rd, o_sdo, o_sdo_valid, o_sof, o_busy, o_byte_cnt} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want all zero",
               {o_fifo_rd, o_sdo, o_sdo_valid, o_sof, o_busy, o_byte_cnt});
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (o_fifo_rd !== 1'b0) begin
        n_err++; $display("FAIL reset_rd cycle %0d: got %b want 0", i, o_fifo_rd);
      end
      n_vec++;
      if (o_busy !== 1'b0) begin
        n_err++; $display("FAIL reset_busy cycle %0d: got %b want 0", i, o_busy);
      end
      n_vec++;
      if (o_byte_cnt !== 16'd0) begin
        n_err++; $display("FAIL reset_cnt cycle %0d: got %0d want 0", i, o_byte_cnt);
      end
    end
    i_en = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] bits;
    int nbits, rd_cyc, lat, rd_w, rd0;
    logic sof_first, sof_extra;
    bit tmo;
    do_reset();
    rd0 = rd_cnt;
    q.push_back(8'hA5);
    i_en = 1'b1;
    capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0) begin n_err++; $display("FAIL single_timeout: got %b want 0", tmo); end
    n_vec++;
    if (rd_w != 1) begin n_err++; $display("FAIL single_rd_width: got %0d want 1", rd_w); end
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_vec++;
    if (nbits != 8 + P) begin
      n_err++; $display("FAIL single_nbits: got %0d want %0d", nbits, 8 + P);
    end
    n_vec++;
    if (bits !== exp_frame(8'hA5)) begin
      n_err++; $display("FAIL single_bits: got %h want %h", bits, exp_frame(8'hA5));
    end
    n_vec++;
    if ({sof_first, sof_extra} !== 2'b10) begin
      n_err++; $display("FAIL single_sof: got first=%b extra=%b want 1/0", sof_first, sof_extra);
    end
    n_vec++;
    if (o_byte_cnt !== 16'd1) begin
      n_err++; $display("FAIL single_cnt_edge: got %0d want 1", o_byte_cnt);
    end
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL single_gap_busy: got %b want 1", o_busy); end
    repeat (20) @(negedge clk);
    n_vec++;
    if (rd_cnt - rd0 != 1) begin
      n_err++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt - rd0);
    end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", o_busy); end
    n_vec++;
    if (o_byte_cnt !== 16'd1) begin
      n_err++; $display("FAIL single_cnt_hold: got %0d want 1", o_byte_cnt);
    end
    i_en = 1'b0;
  endtask

  task automatic test_parity();
    logic [15:0] bits;
    int nbits, rd_cyc, lat, rd_w;
    logic sof_first, sof_extra;
    bit tmo;
    logic [15:0] exp07, expa5;
    exp07 = (P == 1) ? 16'h000F : 16'h0007;
    expa5 = (P == 1) ? 16'h014A : 16'h00A5;
    do_reset();
    q.push_back(8'h07);
    q.push_back(8'hA5);
    i_en = 1'b1;
    capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0 || nbits != 8 + P) begin
      n_err++; $display("FAIL par07_len: got tmo=%b n=%0d want 0/%0d", tmo, nbits, 8 + P);
    end
    n_vec++;
    if (bits !== exp07) begin n_err++; $display("FAIL par07_bits: got %h want %h", bits, exp07); end
    capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0 || nbits != 8 + P) begin
      n_err++; $display("FAIL para5_len: got tmo=%b n=%0d want 0/%0d", tmo, nbits, 8 + P);
    end
    n_vec++;
    if (bits !== expa5) begin n_err++; $display("FAIL para5_bits: got %h want %h", bits, expa5); end
    n_vec++;
    if (o_byte_cnt !== 16'd2) begin n_err++; $display("FAIL par_cnt: got %0d want 2", o_byte_cnt); end
    i_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int nbits, rd_cyc, lat, rd_w, prev_rd;
    logic sof_first, sof_extra;
    bit tmo;
    logic [7:0] bytes [3];
    bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF;
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(bytes[i]);
    repeat (2) @(negedge clk);
    i_en = 1'b1;
    prev_rd = 0;
    for (int i = 0; i < 3; i++) begin
      capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
      n_vec++;
      if (tmo !== 1'b0 || bits !== exp_frame(bytes[i])) begin
        n_err++;
        $display("FAIL b2b_frame%0d: got tmo=%b bits=%h want 0/%h", i, tmo, bits,
                 exp_frame(bytes[i]));
      end
      n_vec++;
      if (sof_first !== 1'b1 || sof_extra !== 1'b0) begin
        n_err++; $display("FAIL b2b_sof%0d: got %b%b want 10", i, sof_first, sof_extra);
      end
      if (i > 0) begin
        n_vec++;
        if (rd_cyc - prev_rd != Period) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: got %0d want %0d", i, rd_cyc - prev_rd, Period);
        end
      end
      prev_rd = rd_cyc;
    end
    n_vec++;
    if (o_byte_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", o_byte_cnt); end
    i_en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [15:0] bits;
    int nbits, rd_cyc, lat, rd_w, rd0;
    logic sof_first, sof_extra;
    bit tmo;
    do_reset();
    rd0 = rd_cnt;
    q.push_back(8'h3C);
    q.push_back(8'hC3);
    i_en = 1'b1;
    capture_frame(2, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0 || bits !== exp_frame(8'h3C)) begin
      n_err++;
      $display("FAIL endrop_frame1: got tmo=%b bits=%h want 0/%h", tmo, bits, exp_frame(8'h3C));
    end
    n_vec++;
    if (o_byte_cnt !== 16'd1) begin n_err++; $display("FAIL endrop_cnt1: got %0d want 1", o_byte_cnt); end
    repeat (30) @(negedge clk);
    n_vec++;
    if (rd_cnt - rd0 != 1) begin
      n_err++; $display("FAIL endrop_no_rd: got %0d reads want 1", rd_cnt - rd0);
    end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL endrop_idle: got %b want 0", o_busy); end
    i_en = 1'b1;
    capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0 || bits !== exp_frame(8'hC3)) begin
      n_err++;
      $display("FAIL endrop_frame2: got tmo=%b bits=%h want 0/%h", tmo, bits, exp_frame(8'hC3));
    end
    n_vec++;
    if (o_byte_cnt !== 16'd2) begin n_err++; $display("FAIL endrop_cnt2: got %0d want 2", o_byte_cnt); end
    i_en = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [15:0] bits;
    int nbits, rd_cyc, lat, rd_w, t, rd0;
    logic sof_first, sof_extra;
    bit tmo;
    do_reset();
    q.push_back(8'h5A);
    q.push_back(8'h96);
    i_en = 1'b1;
    t = 0;
    while (o_sdo_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    // Bit index 5 of 0x5A is 0; bit index 4 is 1
    n_vec++;
    if (o_sdo_valid !== 1'b1 || o_sdo !== 1'b0) begin
      n_err++; $display("FAIL rst_bit5: got valid=%b sdo=%b want 1/0", o_sdo_valid, o_sdo);
    end
    rd0 = rd_cnt;
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_sdo_valid, o_sof, o_busy, o_fifo_rd} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_abort: got valid/sof/busy/rd=%b want 0000",
               {o_sdo_valid, o_sof, o_busy, o_fifo_rd});
    end
    n_vec++;
    if (o_byte_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", o_byte_cnt); end
    repeat (2) @(negedge clk);
    n_vec++;
    if (rd_cnt != rd0) begin n_err++; $display("FAIL rst_no_rd: got %0d reads want 0", rd_cnt - rd0); end
    i_rst_n = 1'b1;
    capture_frame(-1, bits, nbits, rd_cyc, lat, rd_w, sof_first, sof_extra, tmo);
    n_vec++;
    if (tmo !== 1'b0 || bits !== exp_frame(8'h96)) begin
      n_err++;
      $display("FAIL rst_next_frame: got tmo=%b bits=%h want 0/%h", tmo, bits, exp_frame(8'h96));
    end
    n_vec++;
    if (sof_first !== 1'b1 || lat != 2) begin
      n_err++; $display("FAIL rst_next_sof: got sof=%b lat=%0d want 1/2", sof_first, lat);
    end
    n_vec++;
    if (o_byte_cnt !== 16'd1) begin n_err++; $display("FAIL rst_next_cnt: got %0d want 1", o_byte_cnt); end
    i_en = 1'b0;
  endtask

  initial begin
    i_rst_n      = 1'b1;
    i_en         = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = 8'h00;
    #2;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_en_drop();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ser.md
# fifo_drain_ser

Read-side companion for the team's byte FIFO. The block pops bytes from a FIFO with a registered read port, using a one-cycle read strobe and an empty flag. It then shifts each byte out serially, MSB first, with a valid strobe and a start-of-frame marker. It sits between the FIFO's output port and a one-bit serial link or a downstream deserializer.

## Interface
- DATA_W, 8: byte width; minimum 2.
- GAP_CYCLES, 2: idle cycles inserted after each frame; 0 is legal and means no gap.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- en  input  1  drain enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag from the upstream FIFO.
- fifo_data  input  DATA_W  FIFO read data; valid in the cycle after fifo_rd.
- fifo_rd  output  1  FIFO read strobe; one-cycle pulse per byte.
- sdo  output  1  serial data.
- sdo_valid  output  1  high while sdo carries a data or parity bit.
- sof  output  1  high with the first (MSB) bit of each frame.
- busy  output  1  high in every state except IDLE.
- byte_cnt  output  16  count of bytes transmitted; wraps from 0xFFFF to 0.

## Operation
- All outputs are registered.
- Reset values: fifo_rd=0, sdo=0, sdo_valid=0, sof=0, busy=0, byte_cnt=0, state=IDLE, shift register=0.
- FSM states and transitions:
  - IDLE: moves to REQ when en=1 and fifo_empty=0; otherwise stays in IDLE.
  - REQ: fifo_rd=1 for exactly one cycle; then CAPTURE.
  - CAPTURE: loads fifo_data into the shift register and the parity accumulator at the end of the cycle; then SHIFT.
  - SHIFT: DATA_W cycles. sdo = shift register MSB, sdo_valid=1, sof=1 on the first cycle only. The register shifts left by one each cycle. A bit counter runs 0..DATA_W-1.
  - After SHIFT: goes to PAR if PARITY_EN is defined; otherwise to GAP, or to IDLE when GAP_CYCLES=0.
  - PAR: one cycle, sdo = even parity (XOR of the byte's bits), sdo_valid=1; then GAP or IDLE.
  - GAP: GAP_CYCLES cycles with sdo=0 and sdo_valid=0; then IDLE.
- byte_cnt increments by 1 in the cycle after the last bit of the frame is driven (last data bit, or the parity bit when enabled).
- Outside SHIFT and PAR: sdo=0, sdo_valid=0, sof=0.
- Boundary conditions:
  - en falling mid-frame: the current frame completes, and no new read is issued afterwards.
  - fifo_empty rising after fifo_rd: ignored; the captured byte is still sent.
  - fifo_empty is never sampled outside IDLE. Each frame issues exactly one fifo_rd.
  - rst asserted mid-frame: the frame aborts immediately, all outputs take their reset values, and no fifo_rd pulse is emitted.
  - byte_cnt wraps from 0xFFFF to 0x0000 without a flag.

## Timing
- fifo_rd rises one cycle after the clock edge at which IDLE samples en=1 and fifo_empty=0.
- The MSB appears on sdo two cycles after fifo_rd rises.
- Frame period for back-to-back traffic = 3 + DATA_W + P + GAP_CYCLES cycles, where P=1 with PARITY_EN and 0 otherwise. With defaults: 13 cycles without parity, 14 with.
- Two consecutive fifo_rd pulses are never adjacent; the minimum spacing equals the frame period.

## Configuration
- PARITY_EN defined: a PAR state follows SHIFT and emits one even-parity bit with sdo_valid=1. The frame is DATA_W+1 valid bits.
- PARITY_EN undefined: no PAR state and no parity logic. The frame is DATA_W valid bits.

## Test plan
- Reset: hold rst=0 for 2 cycles, release with fifo_empty=1 and en=1 → fifo_rd stays 0, busy=0, byte_cnt=0 for 20 cycles.
- Single byte 0xA5, defaults, no PARITY_EN → one fifo_rd pulse; sdo = 1,0,1,0,0,1,0,1 with sdo_valid=1 for 8 cycles; sof only on the first bit; byte_cnt=1.
- PARITY_EN, byte 0x07 → 8 data bits, then parity bit 1. Byte 0xA5 → parity bit 0.
- Back-to-back: FIFO preloaded with 0x01, 0x80, 0xFF, en=1, GAP_CYCLES=2 → fifo_rd pulses 13 cycles apart; three frames output in order; byte_cnt=3.
- en dropped during the third data bit of frame 1 with 2 bytes queued → frame 1 completes, no second fifo_rd; raising en again sends byte 2.
- rst pulsed during bit 5 → sdo_valid drops immediately, byte_cnt=0. After release, the next queued byte is sent from its MSB with sof=1.
